// File: rtl/vc_mux4_domain_arb_pkg.sv
// Shared types for the domain-aware 4-way mux arbiter.
package vc_mux4_domain_arb_pkg;
  localparam int SCRUB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCRUB = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;
endpackage

// File: rtl/vc_mux4_domain_arb_mux.sv
// Plain 4:1 message multiplexer shared by all requesters.
module vc_Mux4 #(
  parameter int p_nbits = 32
) (
  input  logic [p_nbits-1:0] in0_i,
  input  logic [p_nbits-1:0] in1_i,
  input  logic [p_nbits-1:0] in2_i,
  input  logic [p_nbits-1:0] in3_i,
  input  logic [1:0]         sel_i,
  output logic [p_nbits-1:0] out_o
);
  always_comb begin
    case (sel_i)
      2'd0:    out_o = in0_i;
      2'd1:    out_o = in1_i;
      2'd2:    out_o = in2_i;
      default: out_o = in3_i;
    endcase
  end
endmodule

// File: rtl/vc_mux4_domain_arb.sv
// Round-robin packet arbiter over a shared 4:1 mux; scrubs the port with
// idle zeroed cycles whenever ownership crosses security domains.
module vc_mux4_domain_arb
  import vc_mux4_domain_arb_pkg::*;
#(
  parameter int p_nbits        = 32,
  parameter int p_scrub_cycles = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         req_val,
  output logic [3:0]         req_rdy,
  input  logic [3:0]         req_last,
  input  logic [3:0]         req_domain,
  input  logic [p_nbits-1:0] req_msg0,
  input  logic [p_nbits-1:0] req_msg1,
  input  logic [p_nbits-1:0] req_msg2,
  input  logic [p_nbits-1:0] req_msg3,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out_msg,
  output logic               out_last,
  output logic               out_domain,
  output logic [1:0]         grant
);
  localparam logic [SCRUB_W-1:0] SCRUB_INIT = SCRUB_W'(p_scrub_cycles - 1);

  state_e             state_q;
  logic [1:0]         grant_q;
  logic [1:0]         prio_q;
  logic               cur_domain_q;
  logic [SCRUB_W-1:0] scrub_cnt_q;

  logic               busy;
  logic               xfer;
  logic               win_found;
  logic [1:0]         win_idx;
  logic [1:0]         scan_idx;
  logic [p_nbits-1:0] mux_out;

  // Scan from the highest offset down so the lowest offset from prio wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = prio_q;
    scan_idx  = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      scan_idx = prio_q + 2'(k);
      if (req_val[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  vc_Mux4 #(.p_nbits(p_nbits)) u_mux (
    .in0_i (req_msg0),
    .in1_i (req_msg1),
    .in2_i (req_msg2),
    .in3_i (req_msg3),
    .sel_i (grant_q),
    .out_o (mux_out)
  );

  assign busy       = (state_q == ST_BUSY);
  assign out_val    = busy & req_val[grant_q];
  assign out_last   = busy & req_last[grant_q];
  assign out_msg    = busy ? mux_out : '0;
  assign req_rdy    = busy ? ((4'b0001 << grant_q) & {4{out_rdy}}) : 4'b0000;
  assign out_domain = cur_domain_q;
  assign grant      = grant_q;
  assign xfer       = out_val & out_rdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= 2'd0;
      prio_q       <= 2'd0;
      cur_domain_q <= 1'b0;
      scrub_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            grant_q <= win_idx;
            if (req_domain[win_idx] == cur_domain_q) begin
              state_q <= ST_BUSY;
            end else begin
              cur_domain_q <= req_domain[win_idx];
              scrub_cnt_q  <= SCRUB_INIT;
              state_q      <= ST_SCRUB;
            end
          end
        end
        ST_SCRUB: begin
          if (scrub_cnt_q == '0) state_q <= ST_BUSY;
          else                   scrub_cnt_q <= scrub_cnt_q - 1'b1;
        end
        ST_BUSY: begin
          if (xfer && out_last) begin
            prio_q  <= grant_q + 2'd1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vc_mux4_domain_arb.sv
// Directed bench for vc_mux4_domain_arb with hand-computed expectations.
module tb_vc_mux4_domain_arb;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_val = '0, req_last = '0, req_domain = '0;
  logic [3:0]  req_rdy;
  logic [31:0] m0 = 32'hA000_0000, m1 = 32'hB111_1111, m2 = 32'hC222_2222, m3 = 32'hD333_3333;
  logic        out_val, out_rdy = 1'b0, out_last, out_domain;
  logic [31:0] out_msg;
  logic [1:0]  grant;
  int          n_cmp = 0, n_err = 0;

  vc_mux4_domain_arb #(.p_nbits(32), .p_scrub_cycles(2)) dut (
    .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy),
    .req_last(req_last), .req_domain(req_domain),
    .req_msg0(m0), .req_msg1(m1), .req_msg2(m2), .req_msg3(m3),
    .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg),
    .out_last(out_last), .out_domain(out_domain), .grant(grant)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; req_val = '0; req_last = '0; req_domain = '0; out_rdy = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if ({out_val, req_rdy, out_last, out_domain, grant} !== 9'd0 || out_msg !== 32'd0) begin
      n_err++;
      $display("FAIL reset_state got=%b_%b_%b_%b_%b msg=%h exp=all zero",
               out_val, req_rdy, out_last, out_domain, grant, out_msg);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_msg;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cyc();
      req_val = 4'b1111; req_last = 4'b1111; req_domain = 4'b0000; out_rdy = 1'b1;
      #1;
      n_cmp++;
      if (out_val !== 1'b0 || req_rdy !== 4'b0000) begin
        n_err++;
        $display("FAIL rr_idle%0d got val=%b rdy=%b exp val=0 rdy=0000", k, out_val, req_rdy);
      end
      cyc(); #1;
      case (k % 4)
        0: exp_msg = m0;
        1: exp_msg = m1;
        2: exp_msg = m2;
        default: exp_msg = m3;
      endcase
      n_cmp++;
      if (out_val !== 1'b1 || grant !== 2'(k % 4) || out_msg !== exp_msg ||
          req_rdy !== (4'b0001 << (k % 4)) || out_last !== 1'b1) begin
        n_err++;
        $display("FAIL rr_grant%0d got val=%b g=%0d msg=%h rdy=%b last=%b exp val=1 g=%0d msg=%h",
                 k, out_val, grant, out_msg, req_rdy, out_last, k % 4, exp_msg);
      end
    end
    cyc(); req_val = '0;
  endtask

  task automatic test_domain_switch();
    do_reset();
    cyc(); req_val = 4'b0011; req_last = 4'b1111; req_domain = 4'b0010; out_rdy = 1'b1;
    cyc(); #1;
    n_cmp++;
    if (out_val !== 1'b1 || grant !== 2'd0 || out_domain !== 1'b0 || out_msg !== m0) begin
      n_err++;
      $display("FAIL dom_first got val=%b g=%0d dom=%b msg=%h exp val=1 g=0 dom=0 msg=%h",
               out_val, grant, out_domain, out_msg, m0);
    end
    cyc(); req_val = 4'b0010; #1;
    n_cmp++;
    if (out_val !== 1'b0 || out_domain !== 1'b0) begin
      n_err++;
      $display("FAIL dom_idle got val=%b dom=%b exp val=0 dom=0", out_val, out_domain);
    end
    for (int s = 0; s < 2; s++) begin
      cyc(); #1;
      n_cmp++;
      if (out_val !== 1'b0 || out_msg !== 32'd0 || out_domain !== 1'b1 ||
          req_rdy !== 4'b0000 || grant !== 2'd1) begin
        n_err++;
        $display("FAIL dom_scrub%0d got val=%b msg=%h dom=%b rdy=%b g=%0d exp val=0 msg=0 dom=1 rdy=0000 g=1",
                 s, out_val, out_msg, out_domain, req_rdy, grant);
      end
    end
    cyc(); #1;
    n_cmp++;
    if (out_val !== 1'b1 || out_msg !== m1 || out_domain !== 1'b1 || req_rdy !== 4'b0010) begin
      n_err++;
      $display("FAIL dom_busy got val=%b msg=%h dom=%b rdy=%b exp val=1 msg=%h dom=1 rdy=0010",
               out_val, out_msg, out_domain, req_rdy, m1);
    end
    cyc(); req_val = '0;
  endtask

  task automatic test_multibeat();
    do_reset();
    cyc(); req_val = 4'b1100; req_last = 4'b1000; req_domain = 4'b0000; out_rdy = 1'b1;
    for (int b = 0; b < 3; b++) begin
      cyc();
      if (b == 2) req_last = 4'b1100;
      #1;
      n_cmp++;
      if (out_val !== 1'b1 || grant !== 2'd2 || out_msg !== m2 || out_last !== (b == 2)) begin
        n_err++;
        $display("FAIL mb_beat%0d got val=%b g=%0d msg=%h last=%b exp val=1 g=2 msg=%h last=%0d",
                 b, out_val, grant, out_msg, out_last, m2, b == 2);
      end
    end
    cyc(); req_val = 4'b1000; #1;
    n_cmp++;
    if (out_val !== 1'b0) begin
      n_err++;
      $display("FAIL mb_bubble got val=%b exp val=0", out_val);
    end
    cyc(); #1;
    n_cmp++;
    if (out_val !== 1'b1 || grant !== 2'd3 || out_msg !== m3) begin
      n_err++;
      $display("FAIL mb_next got val=%b g=%0d msg=%h exp val=1 g=3 msg=%h", out_val, grant, out_msg, m3);
    end
    cyc(); req_val = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    cyc(); req_val = 4'b0001; req_last = 4'b0001; req_domain = 4'b0000; out_rdy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cyc(); #1;
      n_cmp++;
      if (out_val !== 1'b1 || req_rdy !== 4'b0000 || out_msg !== m0 || grant !== 2'd0) begin
        n_err++;
        $display("FAIL bp_stall%0d got val=%b rdy=%b msg=%h g=%0d exp val=1 rdy=0000 msg=%h g=0",
                 c, out_val, req_rdy, out_msg, grant, m0);
      end
    end
    cyc(); out_rdy = 1'b1; #1;
    n_cmp++;
    if (out_val !== 1'b1 || req_rdy !== 4'b0001) begin
      n_err++;
      $display("FAIL bp_release got val=%b rdy=%b exp val=1 rdy=0001", out_val, req_rdy);
    end
    cyc(); req_val = '0; #1;
    n_cmp++;
    if (out_val !== 1'b0 || req_rdy !== 4'b0000) begin
      n_err++;
      $display("FAIL bp_done got val=%b rdy=%b exp val=0 rdy=0000", out_val, req_rdy);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    cyc(); req_val = 4'b0100; req_last = 4'b1111; req_domain = 4'b0000; out_rdy = 1'b1;
    cyc(); #1;
    n_cmp++;
    if (grant !== 2'd2 || out_val !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_setup got g=%0d val=%b exp g=2 val=1", grant, out_val);
    end
    cyc(); req_val = 4'b1001;
    cyc(); #1;
    n_cmp++;
    if (grant !== 2'd3 || out_val !== 1'b1 || out_msg !== m3) begin
      n_err++;
      $display("FAIL wrap_first got g=%0d val=%b msg=%h exp g=3 val=1 msg=%h", grant, out_val, out_msg, m3);
    end
    cyc(); req_val = 4'b0001;
    cyc(); #1;
    n_cmp++;
    if (grant !== 2'd0 || out_val !== 1'b1 || out_msg !== m0) begin
      n_err++;
      $display("FAIL wrap_second got g=%0d val=%b msg=%h exp g=0 val=1 msg=%h", grant, out_val, out_msg, m0);
    end
    cyc(); req_val = '0;
  endtask

  task automatic test_reset_midpacket();
    do_reset();
    cyc(); req_val = 4'b1111; req_last = 4'b0000; req_domain = 4'b1111; out_rdy = 1'b1;
    cyc(); cyc(); cyc(); #1;
    n_cmp++;
    if (out_val !== 1'b1 || out_domain !== 1'b1 || grant !== 2'd0) begin
      n_err++;
      $display("FAIL rst_pre got val=%b dom=%b g=%0d exp val=1 dom=1 g=0", out_val, out_domain, grant);
    end
    cyc(); #1;
    reset = 1'b0; #1;
    n_cmp++;
    if ({out_val, req_rdy, out_last, out_domain, grant} !== 9'd0 || out_msg !== 32'd0) begin
      n_err++;
      $display("FAIL rst_async got=%b_%b_%b_%b_%b msg=%h exp=all zero",
               out_val, req_rdy, out_last, out_domain, grant, out_msg);
    end
    cyc(); reset = 1'b1; req_domain = 4'b0000; req_last = 4'b1111;
    cyc(); #1;
    n_cmp++;
    if (out_val !== 1'b1 || grant !== 2'd0 || out_domain !== 1'b0 || out_msg !== m0) begin
      n_err++;
      $display("FAIL rst_regrant got val=%b g=%0d dom=%b msg=%h exp val=1 g=0 dom=0 msg=%h",
               out_val, grant, out_domain, out_msg, m0);
    end
    cyc(); req_val = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_domain_switch();
    test_multibeat();
    test_backpressure();
    test_wrap();
    test_reset_midpacket();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/vc_mux4_domain_arb.md
# vc_mux4_domain_arb

Round-robin arbiter and sequencer that shares one 4-input message mux (vc_Mux4) among four requesters, each tagged with a one-bit security domain. It grants whole multi-beat packets, drives the mux select and domain label, and inserts a fixed scrub interval of idle, zeroed output whenever ownership passes between domains. It sits between the per-requester queues and the single shared downstream port (memory/network side) of the system.

## Interface
- p_nbits, 32, message width carried through the mux
- p_scrub_cycles, 2, idle cycles inserted on a domain change; legal range 1–15
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; asserting it (0) clears all state immediately
- req_val  in  4  per-requester valid
- req_rdy  out  4  per-requester ready; one-hot or zero
- req_last  in  4  marks final beat of a packet
- req_domain  in  4  domain bit of each requester; constant while req_val is high
- req_msg0..req_msg3  in  p_nbits each  requester messages
- out_val  out  1  downstream valid
- out_rdy  in  1  downstream ready
- out_msg  out  p_nbits  muxed message; all-zero unless in BUSY
- out_last  out  1  req_last of granted requester, gated by BUSY
- out_domain  out  1  current owning domain
- grant  out  2  index of current/last owner (mux select)

## Operation
- States: IDLE, SCRUB, BUSY. Registers: state, grant[1:0], prio[1:0] (round-robin pointer), cur_domain, scrub_cnt[3:0].
- IDLE: winner = first i with req_val[i] set, scanning prio, prio+1, prio+2, prio+3 (mod 4). No request: stay IDLE. Winner found: grant ← winner; if req_domain[winner] == cur_domain go BUSY, else cur_domain ← req_domain[winner], scrub_cnt ← p_scrub_cycles−1, go SCRUB.
- SCRUB: out_val=0, out_msg=0, req_rdy=0. scrub_cnt decrements; at 0 go BUSY.
- BUSY: out_val = req_val[grant]; req_rdy[grant] = out_rdy, other bits 0; out_msg = req_msg[grant] via vc_Mux4 (sel=grant, domain=cur_domain); out_last = req_last[grant].
- Beat transfer = out_val & out_rdy. Transfer with out_last: prio ← grant+1 (mod 4 wrap, 3→0), go IDLE. Transfer without last: stay BUSY; grant held regardless of other requests or req_val dropping.
- out_domain = cur_domain in all states; grant output = grant register.
- Requesters dropping req_val during SCRUB: BUSY still entered; out_val follows req_val[grant] (zero) until it returns.
- Outside BUSY: out_val=0, out_last=0, out_msg=0, req_rdy=0.

## Timing
- Reset (reset=0, async): state=IDLE, grant=0, prio=0, cur_domain=0, scrub_cnt=0; hence out_val=0, req_rdy=0, out_msg=0, out_last=0, out_domain=0, grant=0. Reset during BUSY/SCRUB aborts packet; no partial state survives.
- Same-domain grant: request sampled in IDLE at cycle t; out_val at t+1.
- Cross-domain grant: out_val at t+1+p_scrub_cycles; out_domain changes at t+1.
- Packet end → next grant: one IDLE bubble cycle minimum (no back-to-back packets).
- Data path from req_msg/req_val/out_rdy to out_msg/out_val/req_rdy is combinational in BUSY; no buffering.
- Simultaneous requests: pointer order decides; after serving i, i has lowest priority.

## Structure
- Shared package: state encodings (IDLE=2'd0, SCRUB=2'd1, BUSY=2'd2), scrub counter width constant.
- Sub-module: one vc_Mux4 instance (p_nbits) for message select; output gated to zero outside BUSY. Priority scan and FSM inline.

## Test plan
- Reset: drive reset=0 mid-packet with req_val=4'b1111 -> all outputs 0 immediately, after release first grant goes to requester 0.
- Round-robin: all four request, domain 0, single-beat packets, out_rdy=1 -> grants 0,1,2,3,0 with one IDLE cycle between each.
- Domain switch, p_scrub_cycles=2: req 0 (domain 0) finishes, req 1 (domain 1) -> out_domain=1 next cycle, out_val and out_msg 0 for 2 cycles, then req_msg1 appears.
- Multi-beat hold: requester 2 sends 3 beats (last on 3rd), requester 3 requests throughout -> grant stays 2 for all 3 beats, then moves to 3.
- Backpressure: out_rdy=0 for 4 cycles in BUSY -> req_rdy=0, out_val=1, out_msg stable at req_msg of grant; transfer completes when out_rdy=1.
- Wrap: prio=3, requests on 0 and 3 -> grant 3 first, then 0.
